// File: rtl/nfc_pkg.sv
// nfc_pkg
//   Definitions shared by the NFC atomic command/address sequencer:
//   - the ACG slot indices,
//   - the one-hot FSM state encodings,
//   - the NAND timing defaults, in system clock cycles,
//   - a helper that picks byte k out of the 40-bit CA word.
//   This file has no ports.
package nfc_pkg;

   localparam int cAcgSlotAcs = 3;
   localparam int cAcgSlotDis = 1;

   localparam int cSetupCyclesDefault  = 1;
   localparam int cWELowCyclesDefault  = 2;
   localparam int cWEHighCyclesDefault = 2;
   localparam int cHoldCyclesDefault   = 1;

   localparam int cTimerWidth     = 4;
   localparam int cMaxTimerCycles = 15;

   typedef enum logic [5:0] {
      sIdle   = 6'b000001,
      sSetup  = 6'b000010,
      sWELow  = 6'b000100,
      sWEHigh = 6'b001000,
      sHold   = 6'b010000,
      sDone   = 6'b100000
   } caState_t;

   // Byte 0 is the most significant byte, and it goes out on the bus first.
   function automatic logic [7:0] caByte(input logic [39:0] caData, input logic [2:0] byteIdx);
      logic [7:0] selByte;
      case (byteIdx)
         3'd0:    selByte = caData[39:32];
         3'd1:    selByte = caData[31:24];
         3'd2:    selByte = caData[23:16];
         3'd3:    selByte = caData[15:8];
         3'd4:    selByte = caData[7:0];
         default: selByte = 8'h00;
      endcase
      return selByte;
   endfunction

endpackage

// File: rtl/nfc_cycle_timer.sv
// nfc_cycle_timer
//   Loadable down-counter. It is loaded with (cycles - 1) when a state is entered.
//   oTerminal is high while the count is zero, which marks the last cycle of that state.
//   Ports:
//     iSystemClock  in   clock
//     iReset        in   synchronous, active-high reset (clears the count)
//     iLoad         in   load iLoadValue on this edge
//     iLoadValue    in   pWidth-bit start value
//     oTerminal     out  count == 0
module nfc_cycle_timer #(
   parameter int pWidth = 4
) (
   input  logic              iSystemClock,
   input  logic              iReset,
   input  logic              iLoad,
   input  logic [pWidth-1:0] iLoadValue,
   output logic              oTerminal
);

   logic [pWidth-1:0] count;

   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         count <= '0;
      end else if (iLoad) begin
         count <= iLoadValue;
      end else if (count != '0) begin
         count <= count - pWidth'(1);
      end
   end

   assign oTerminal = (count == '0);

endmodule

// File: rtl/nfc_atom_cmd_addr_sync.sv
// nfc_atom_cmd_addr_sync
//   Atomic command/address sequencer for ACG slot 3. It sends one command byte
//   (iCASelect=1) or an address burst of 1..5 bytes (iCASelect=0) on the SDR NAND pins.
//   The cycle timing is set by parameters.
//   Ports:
//     iSystemClock, iReset          clock, synchronous active-high reset
//     iStart                        request; taken only while oReady=1
//     iTargetWay[NumberOfWays]      way mask (CE# = ~mask)
//     iCASelect                     1 = command, 0 = address
//     iCAData[40]                   byte k = iCAData[39-8k -: 8]
//     iNumOfData[16]                address bytes - 1, clamped to 4
//     oReady, oLastStep             idle flag, one-cycle done pulse
//     oCE_n, oCLE, oALE, oWE_n      NAND control pins (all registered)
//     oDQ, oDQ_OE                   NAND data bus and its output enable
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   sIdle   | pins at rest; oReady=1; iStart latches the request
//   sSetup  | CE#/CLE/ALE/DQ driven ahead of the first WE# fall
//   sWELow  | WE# low for the current byte
//   sWEHigh | WE# high; the NAND latches on the rise; DQ still held
//   sHold   | CE#/CLE/ALE held after the last WE# rise
//   sDone   | pins at rest; oLastStep pulse
module nfc_atom_cmd_addr_sync
   import nfc_pkg::*;
#(
   parameter int NumberOfWays  = 4,
   parameter int pSetupCycles  = cSetupCyclesDefault,
   parameter int pWELowCycles  = cWELowCyclesDefault,
   parameter int pWEHighCycles = cWEHighCyclesDefault,
   parameter int pHoldCycles   = cHoldCyclesDefault
) (
   input  logic                    iSystemClock,
   input  logic                    iReset,
   input  logic                    iStart,
   input  logic [NumberOfWays-1:0] iTargetWay,
   input  logic                    iCASelect,
   input  logic [39:0]             iCAData,
   input  logic [15:0]             iNumOfData,
   output logic                    oReady,
   output logic                    oLastStep,
   output logic [NumberOfWays-1:0] oCE_n,
   output logic                    oCLE,
   output logic                    oALE,
   output logic                    oWE_n,
   output logic [7:0]              oDQ,
   output logic                    oDQ_OE
);

   if (pSetupCycles < 1 || pSetupCycles > cMaxTimerCycles ||
       pWELowCycles < 1 || pWELowCycles > cMaxTimerCycles ||
       pWEHighCycles < 1 || pWEHighCycles > cMaxTimerCycles ||
       pHoldCycles < 1 || pHoldCycles > cMaxTimerCycles) begin : gParamCheck
      $error("nfc_atom_cmd_addr_sync: cycle parameters must be in 1..15");
   end

   localparam logic [cTimerWidth-1:0] cSetupLoad  = cTimerWidth'(pSetupCycles - 1);
   localparam logic [cTimerWidth-1:0] cWELowLoad  = cTimerWidth'(pWELowCycles - 1);
   localparam logic [cTimerWidth-1:0] cWEHighLoad = cTimerWidth'(pWEHighCycles - 1);
   localparam logic [cTimerWidth-1:0] cHoldLoad   = cTimerWidth'(pHoldCycles - 1);

   caState_t                state, stateNext;
   logic [NumberOfWays-1:0] wayQ, wayNext;
   logic                    caSelQ, caSelNext;
   logic [39:0]             caDataQ, caDataNext;
   logic [2:0]              lastIdxQ, lastIdxNext;
   logic [2:0]              byteIdxQ, byteIdxNext;

   logic                    timerLoad;
   logic [cTimerWidth-1:0]  timerValue;
   logic                    timerDone;

   logic                    pinsActive;

   nfc_cycle_timer #(
      .pWidth(cTimerWidth)
   ) uCycleTimer (
      .iSystemClock(iSystemClock),
      .iReset      (iReset),
      .iLoad       (timerLoad),
      .iLoadValue  (timerValue),
      .oTerminal   (timerDone)
   );

   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         state    <= sIdle;
         wayQ     <= '0;
         caSelQ   <= 1'b0;
         caDataQ  <= '0;
         lastIdxQ <= '0;
         byteIdxQ <= '0;
      end else begin
         state    <= stateNext;
         wayQ     <= wayNext;
         caSelQ   <= caSelNext;
         caDataQ  <= caDataNext;
         lastIdxQ <= lastIdxNext;
         byteIdxQ <= byteIdxNext;
      end
   end

   always_comb begin
      stateNext   = state;
      wayNext     = wayQ;
      caSelNext   = caSelQ;
      caDataNext  = caDataQ;
      lastIdxNext = lastIdxQ;
      byteIdxNext = byteIdxQ;
      timerLoad   = 1'b0;
      timerValue  = '0;

      unique case (state)
         sIdle: begin
            if (iStart) begin
               wayNext     = iTargetWay;
               caSelNext   = iCASelect;
               caDataNext  = iCAData;
               // A command is always one byte. An address burst is limited to 5 bytes.
               lastIdxNext = iCASelect ? 3'd0 :
                             (iNumOfData > 16'd4) ? 3'd4 : iNumOfData[2:0];
               byteIdxNext = 3'd0;
               stateNext   = sSetup;
               timerLoad   = 1'b1;
               timerValue  = cSetupLoad;
            end
         end
         sSetup: begin
            if (timerDone) begin
               stateNext  = sWELow;
               timerLoad  = 1'b1;
               timerValue = cWELowLoad;
            end
         end
         sWELow: begin
            if (timerDone) begin
               stateNext  = sWEHigh;
               timerLoad  = 1'b1;
               timerValue = cWEHighLoad;
            end
         end
         sWEHigh: begin
            if (timerDone) begin
               timerLoad = 1'b1;
               if (byteIdxQ != lastIdxQ) begin
                  byteIdxNext = byteIdxQ + 3'd1;
                  stateNext   = sWELow;
                  timerValue  = cWELowLoad;
               end else begin
                  stateNext  = sHold;
                  timerValue = cHoldLoad;
               end
            end
         end
         sHold: begin
            if (timerDone) begin
               stateNext = sDone;
            end
         end
         sDone: begin
            stateNext = sIdle;
         end
         default: begin
            stateNext = sIdle;
         end
      endcase
   end

   // The pin registers are loaded from the next state and the next latched values.
   // This makes every pin change on the same edge as its state change, so the first
   // SETUP cycle already shows the latched request.
   assign pinsActive = stateNext inside {sSetup, sWELow, sWEHigh, sHold};

   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         oReady    <= 1'b1;
         oLastStep <= 1'b0;
         oCE_n     <= '1;
         oCLE      <= 1'b0;
         oALE      <= 1'b0;
         oWE_n     <= 1'b1;
         oDQ       <= 8'h00;
         oDQ_OE    <= 1'b0;
      end else begin
         oReady    <= (stateNext == sIdle);
         oLastStep <= (stateNext == sDone);
         oCE_n     <= pinsActive ? ~wayNext : '1;
         oCLE      <= pinsActive & caSelNext;
         oALE      <= pinsActive & ~caSelNext;
         oWE_n     <= (stateNext != sWELow);
         oDQ       <= pinsActive ? caByte(caDataNext, byteIdxNext) : 8'h00;
         oDQ_OE    <= pinsActive;
      end
   end

endmodule

// File: tb/tb_nfc_atom_cmd_addr_sync.sv
module tb_nfc_atom_cmd_addr_sync;

   logic        iSystemClock = 1'b0;
   logic        iReset = 1'b1;
   logic        iStart = 1'b0;
   logic [3:0]  iTargetWay = 4'h0;
   logic        iCASelect = 1'b0;
   logic [39:0] iCAData = 40'h0;
   logic [15:0] iNumOfData = 16'h0;
   logic        oReady, oLastStep, oCLE, oALE, oWE_n, oDQ_OE;
   logic [3:0]  oCE_n;
   logic [7:0]  oDQ;

   nfc_atom_cmd_addr_sync dut (
      .iSystemClock(iSystemClock),
      .iReset      (iReset),
      .iStart      (iStart),
      .iTargetWay  (iTargetWay),
      .iCASelect   (iCASelect),
      .iCAData     (iCAData),
      .iNumOfData  (iNumOfData),
      .oReady      (oReady),
      .oLastStep   (oLastStep),
      .oCE_n       (oCE_n),
      .oCLE        (oCLE),
      .oALE        (oALE),
      .oWE_n       (oWE_n),
      .oDQ         (oDQ),
      .oDQ_OE      (oDQ_OE)
   );

   always #5 iSystemClock = ~iSystemClock;

   typedef struct {
      logic        caSel;
      logic [39:0] caData;
      logic [15:0] numOfData;
      logic [3:0]  way;
      int          expLast;
      int          expCount;
      logic [39:0] expBytes;
      logic [3:0]  expCE;
      logic        expCLE;
      logic        expALE;
   } vec_t;

   vec_t vecs[7];

   int passed = 0;
   int total = 0;

   int          lastCyc, gotCount, weBad, readyBad;
   logic [39:0] gotBytes;
   logic [3:0]  firstCE;
   logic        firstCLE, firstALE, firstOE;
   logic [7:0]  logBytes[16];
   int          logCount = 0;

   localparam logic [17:0] cRestPins = {1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0};

   function automatic logic [17:0] pinVec();
      return {oReady, oLastStep, oCE_n, oCLE, oALE, oWE_n, oDQ, oDQ_OE};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      else passed++;
   endtask

   // The accepting edge has just happened. Each following negedge is one more cycle (1, 2, ...).
   task automatic watchOp();
      logic prevWe;
      int   lowLen;
      lastCyc = 0; gotCount = 0; weBad = 0; readyBad = 0; gotBytes = '0;
      prevWe = 1'b1; lowLen = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge iSystemClock);
         if (c == 1) begin
            firstCE = oCE_n; firstCLE = oCLE; firstALE = oALE; firstOE = oDQ_OE;
         end
         if (oReady) readyBad++;
         if (!oWE_n) lowLen++;
         else if (!prevWe) begin
            if (gotCount < 5) gotBytes[39-8*gotCount -: 8] = oDQ;
            if (logCount < 16) begin logBytes[logCount] = oDQ; logCount++; end
            gotCount++;
            if (lowLen != 2) weBad++;
            lowLen = 0;
         end
         prevWe = oWE_n;
         if (oLastStep) begin
            lastCyc = c;
            break;
         end
      end
   endtask

   task automatic checkOp(input int i);
      check($sformatf("v%0d_lastcycle", i), 64'(lastCyc), 64'(vecs[i].expLast));
      check($sformatf("v%0d_bytecount", i), 64'(gotCount), 64'(vecs[i].expCount));
      check($sformatf("v%0d_bytes", i), 64'(gotBytes), 64'(vecs[i].expBytes));
      check($sformatf("v%0d_ce", i), 64'(firstCE), 64'(vecs[i].expCE));
      check($sformatf("v%0d_cle_ale", i), 64'({firstCLE, firstALE}), 64'({vecs[i].expCLE, vecs[i].expALE}));
      check($sformatf("v%0d_dq_oe", i), 64'(firstOE), 64'd1);
      check($sformatf("v%0d_we_width_errs", i), 64'(weBad), 64'd0);
      check($sformatf("v%0d_ready_busy_errs", i), 64'(readyBad), 64'd0);
   endtask

   task automatic driveVec(input int i);
      iCASelect  = vecs[i].caSel;
      iCAData    = vecs[i].caData;
      iNumOfData = vecs[i].numOfData;
      iTargetWay = vecs[i].way;
   endtask

   task automatic runVec(input int i);
      @(posedge iSystemClock); #1;
      driveVec(i);
      iStart = 1'b1;
      @(posedge iSystemClock); #1;
      iStart = 1'b0;
      // Scramble the inputs while busy; the DUT must use its latched copy.
      iCASelect  = ~vecs[i].caSel;
      iCAData    = ~vecs[i].caData;
      iTargetWay = ~vecs[i].way;
      iNumOfData = 16'd1;
      watchOp();
      checkOp(i);
      @(negedge iSystemClock);
      check($sformatf("v%0d_ready_after", i), 64'({oReady, oLastStep}), 64'b10);
   endtask

   initial begin
      int extra;
      logic [63:0] seq;

      //          caSel  caData            nd        way      last cnt expBytes          CE       CLE   ALE
      vecs[0] = '{1'b1, 40'h30_12_34_56_78, 16'd3,    4'b0010, 7,  1, 40'h30_00_00_00_00, 4'b1101, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 40'h11_22_33_44_55, 16'd4,    4'b0001, 23, 5, 40'h11_22_33_44_55, 4'b1110, 1'b0, 1'b1};
      vecs[2] = '{1'b0, 40'hAA_BB_CC_DD_EE, 16'd9,    4'b1000, 23, 5, 40'hAA_BB_CC_DD_EE, 4'b0111, 1'b0, 1'b1};
      vecs[3] = '{1'b0, 40'h5A_66_77_88_99, 16'd0,    4'b0100, 7,  1, 40'h5A_00_00_00_00, 4'b1011, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 40'h01_02_03_04_05, 16'd2,    4'b1111, 15, 3, 40'h01_02_03_00_00, 4'b0000, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 40'h90_AB_CD_EF_01, 16'd0,    4'b0000, 7,  1, 40'h90_00_00_00_00, 4'b1111, 1'b1, 1'b0};
      vecs[6] = '{1'b0, 40'hC1_C2_C3_C4_C5, 16'hFFFF, 4'b0011, 23, 5, 40'hC1_C2_C3_C4_C5, 4'b1100, 1'b0, 1'b1};

      // Reset, then 20 idle cycles at the rest values.
      repeat (3) @(posedge iSystemClock);
      #1 iReset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge iSystemClock);
         check($sformatf("idle_pins_c%0d", c), 64'(pinVec()), 64'(cRestPins));
      end

      for (int i = 0; i < 7; i++) runVec(i);

      // Read-page sequence with iStart held high: 00h, 5 address bytes, 30h.
      logCount = 0;
      @(posedge iSystemClock); #1;
      iCASelect = 1'b1; iCAData = 40'h00_00_00_00_00; iTargetWay = 4'b0001; iNumOfData = 16'd0;
      iStart = 1'b1;
      @(posedge iSystemClock);
      watchOp();
      check("rp_cmd00_last", 64'(lastCyc), 64'd7);
      @(posedge iSystemClock); #1;
      iCASelect = 1'b0; iCAData = 40'h01_02_03_04_05; iNumOfData = 16'd4;
      @(negedge iSystemClock);
      check("rp_gap1_ready", 64'({oReady, oLastStep}), 64'b10);
      @(posedge iSystemClock);
      watchOp();
      check("rp_addr_first_cycle_oe", 64'(firstOE), 64'd1);
      check("rp_addr_last", 64'(lastCyc), 64'd23);
      @(posedge iSystemClock); #1;
      iCASelect = 1'b1; iCAData = 40'h30_00_00_00_00; iNumOfData = 16'd0;
      @(negedge iSystemClock);
      check("rp_gap2_ready", 64'({oReady, oLastStep}), 64'b10);
      @(posedge iSystemClock);
      watchOp();
      check("rp_cmd30_first_cycle_oe", 64'(firstOE), 64'd1);
      check("rp_cmd30_last", 64'(lastCyc), 64'd7);
      @(posedge iSystemClock); #1;
      iStart = 1'b0;
      extra = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge iSystemClock);
         if (!oReady || !oWE_n || oDQ_OE) extra++;
      end
      check("rp_no_fourth_op", 64'(extra), 64'd0);
      check("rp_byte_count", 64'(logCount), 64'd7);
      seq = '0;
      for (int k = 0; k < 7 && k < logCount; k++) seq[55-8*k -: 8] = logBytes[k];
      check("rp_byte_sequence", seq, 64'h00_00_01_02_03_04_05_30);

      // Reset during the WE_LOW of the 3rd address byte (cycles 10-11 of this op).
      @(posedge iSystemClock); #1;
      driveVec(1);
      iStart = 1'b1;
      @(posedge iSystemClock); #1;
      iStart = 1'b0;
      for (int c = 1; c <= 10; c++) @(negedge iSystemClock);
      check("rst_pre_we_low", 64'({oWE_n, oDQ}), 64'({1'b0, 8'h33}));
      iReset = 1'b1;
      @(negedge iSystemClock);
      check("rst_pins_rest", 64'(pinVec()), 64'(cRestPins));
      iReset = 1'b0;
      extra = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge iSystemClock);
         if (oLastStep) extra++;
      end
      check("rst_no_laststep", 64'(extra), 64'd0);
      runVec(0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
